// File: rtl/softmax_rdma.sv
`default_nettype none
// ============================================================================
// Module      : softmax_rdma
// Description : Read DMA for the Softmax engine.
//               - Issues MCIF burst read commands.
//               - Loop order, innermost first: channel group, then w-burst,
//                 then row. This matches the Softmax write DMA addressing.
//               - Forwards in-order read data to the Softmax datapath and
//                 zeroes every beat whose pixel index is >= pixel_in.
//               - Pulses rdma_done once the last beat has been accepted
//                 downstream.
// Ports       : clk, rst_n (async, active-low)
//               start, w, h, pixel_in, ch_div_Tout,
//                 feature_base_addr, feature_surface_stride
//                 (job configuration, latched on an accepted start)
//               rd_req_vld/rdy/pd : MCIF read command channel
//               rd_rsp_vld/rdy/pd : MCIF read data channel (in order)
//               dat_out_vld/rdy/pd: masked beats toward the Softmax datapath
//               rdma_done         : one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module softmax_rdma #(
    parameter int TOUT            = 8,
    parameter int DAT_DW          = 16,
    parameter int LOG2_W          = 12,
    parameter int LOG2_H          = 12,
    parameter int LOG2_CH         = 12,
    parameter int LOG2_TOUT       = 3,
    parameter int LOG2_BURST      = 4,
    parameter int PIXEL_BYTES     = 16,
    parameter int LOG2_PIXEL      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [LOG2_W-1:0]              w,
    input  logic [LOG2_H-1:0]              h,
    input  logic [LOG2_PIXEL-1:0]          pixel_in,
    input  logic [LOG2_CH-LOG2_TOUT-1:0]   ch_div_Tout,
    input  logic [31:0]                    feature_base_addr,
    input  logic [25:0]                    feature_surface_stride,
    output logic                           rdma_done,
    output logic                           rd_req_vld,
    input  logic                           rd_req_rdy,
    output logic [64+LOG2_BURST-1:0]       rd_req_pd,
    input  logic                           rd_rsp_vld,
    input  logic [TOUT*DAT_DW-1:0]         rd_rsp_pd,
    output logic                           rd_rsp_rdy,
    output logic                           dat_out_vld,
    output logic [TOUT*DAT_DW-1:0]         dat_out_pd,
    input  logic                           dat_out_rdy
);

    localparam int          c_chw     = LOG2_CH - LOG2_TOUT;
    localparam int          c_wbw     = LOG2_W - LOG2_BURST;
    localparam int          c_ow      = $clog2(MAX_OUTSTANDING + 1);
    localparam int          c_burst   = 2 ** LOG2_BURST;
    localparam logic [31:0] c_wb_step = 32'(c_burst * PIXEL_BYTES);

    // Latched job configuration
    logic [LOG2_W-1:0]     r_w;
    logic [LOG2_H-1:0]     r_h;
    logic [LOG2_PIXEL-1:0] r_pix;
    logic [c_chw-1:0]      r_chd;
    logic [31:0]           r_base;
    logic [25:0]           r_stride;
    logic [31:0]           r_hstep;   // row step in bytes: w * PIXEL_BYTES

    logic                  r_req_busy;
    logic                  r_rsp_busy;
    logic [c_ow-1:0]       r_outstanding;
    logic                  r_done;

    // Request-side loop counters and running address biases
    logic [c_chw-1:0]      r_ch_cnt;
    logic [c_wbw-1:0]      r_wb_cnt;
    logic [LOG2_H-1:0]     r_h_cnt;
    logic [31:0]           r_ch_off;
    logic [31:0]           r_wb_off;
    logic [31:0]           r_h_off;

    // Response-side mirror of the same loop, advanced per accepted beat
    logic [LOG2_BURST-1:0] r_beat_cnt;
    logic [c_chw-1:0]      r_rch_cnt;
    logic [c_wbw-1:0]      r_rwb_cnt;
    logic [LOG2_H-1:0]     r_rh_cnt;
    logic [31:0]           r_rh_pix;

    logic [LOG2_W-1:0]     w_w_m1;
    logic [c_wbw-1:0]      w_wb_max;
    logic [LOG2_BURST-1:0] w_last_len;
    logic                  w_ch_last;
    logic                  w_wb_last;
    logic                  w_h_last;
    logic [LOG2_BURST-1:0] w_req_len;
    logic [31:0]           w_req_off;
    logic                  w_cmd_hs;
    logic                  w_final_cmd;
    logic                  w_rch_last;
    logic                  w_rwb_last;
    logic                  w_rh_last;
    logic [LOG2_BURST-1:0] w_beat_max;
    logic                  w_beat_last;
    logic                  w_beat_acc;
    logic                  w_burst_end;
    logic                  w_final_beat;
    logic [31:0]           w_cur_pixel;
    logic                  w_masked;
    logic                  w_start;

    // Index of the last w-burst in a row.
    // The last burst carries the w remainder. A remainder of 0 wraps the
    // length to all-ones, which is a full burst.
    assign w_w_m1     = r_w - LOG2_W'(1);
    assign w_wb_max   = w_w_m1[LOG2_W-1:LOG2_BURST];
    assign w_last_len = r_w[LOG2_BURST-1:0] - LOG2_BURST'(1);

    assign w_start    = start & ~r_req_busy & ~r_rsp_busy;

    // ------------------------------------------------------------------
    // Command side
    // ------------------------------------------------------------------
    assign w_ch_last   = (r_ch_cnt == r_chd - c_chw'(1));
    assign w_wb_last   = (r_wb_cnt == w_wb_max);
    assign w_h_last    = (r_h_cnt  == r_h - LOG2_H'(1));
    assign w_req_len   = w_wb_last ? w_last_len : {LOG2_BURST{1'b1}};
    assign w_req_off   = r_h_off + r_wb_off + r_ch_off;

    assign rd_req_vld  = r_req_busy & (r_outstanding < c_ow'(MAX_OUTSTANDING));
    assign rd_req_pd   = {r_base, w_req_len, w_req_off};
    assign w_cmd_hs    = rd_req_vld & rd_req_rdy;
    assign w_final_cmd = w_cmd_hs & w_ch_last & w_wb_last & w_h_last;

    // ------------------------------------------------------------------
    // Response side: zero-latency pass-through with pixel masking
    // ------------------------------------------------------------------
    assign w_rch_last   = (r_rch_cnt == r_chd - c_chw'(1));
    assign w_rwb_last   = (r_rwb_cnt == w_wb_max);
    assign w_rh_last    = (r_rh_cnt  == r_h - LOG2_H'(1));
    assign w_beat_max   = w_rwb_last ? w_last_len : {LOG2_BURST{1'b1}};
    assign w_beat_last  = (r_beat_cnt == w_beat_max);

    assign w_beat_acc   = r_rsp_busy & rd_rsp_vld & dat_out_rdy;
    assign w_burst_end  = w_beat_acc & w_beat_last;
    assign w_final_beat = w_burst_end & w_rch_last & w_rwb_last & w_rh_last;

    // Pixel index of the beat currently presented. It does not depend on
    // the channel group, because every group walks the same pixels.
    assign w_cur_pixel  = r_rh_pix + (32'(r_rwb_cnt) << LOG2_BURST) + 32'(r_beat_cnt);
    assign w_masked     = (w_cur_pixel >= 32'(r_pix));

    assign dat_out_vld  = r_rsp_busy & rd_rsp_vld;
    assign rd_rsp_rdy   = r_rsp_busy & dat_out_rdy;
    assign dat_out_pd   = w_masked ? '0 : rd_rsp_pd;
    assign rdma_done    = r_done;

    // ------------------------------------------------------------------
    // Job configuration and busy flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w        <= '0;
            r_h        <= '0;
            r_pix      <= '0;
            r_chd      <= '0;
            r_base     <= '0;
            r_stride   <= '0;
            r_hstep    <= '0;
            r_req_busy <= 1'b0;
            r_rsp_busy <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_final_beat;
            if (w_start) begin
                r_w        <= w;
                r_h        <= h;
                r_pix      <= pixel_in;
                r_chd      <= ch_div_Tout;
                r_base     <= feature_base_addr;
                r_stride   <= feature_surface_stride;
                r_hstep    <= 32'(w) * 32'(PIXEL_BYTES);
                r_req_busy <= 1'b1;
                r_rsp_busy <= 1'b1;
            end else begin
                if (w_final_cmd) begin
                    r_req_busy <= 1'b0;
                end
                if (w_final_beat) begin
                    r_rsp_busy <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command loop counters and biases
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_cnt <= '0;
            r_wb_cnt <= '0;
            r_h_cnt  <= '0;
            r_ch_off <= '0;
            r_wb_off <= '0;
            r_h_off  <= '0;
        end else if (w_start) begin
            r_ch_cnt <= '0;
            r_wb_cnt <= '0;
            r_h_cnt  <= '0;
            r_ch_off <= '0;
            r_wb_off <= '0;
            r_h_off  <= '0;
        end else if (w_cmd_hs) begin
            if (!w_ch_last) begin
                r_ch_cnt <= r_ch_cnt + c_chw'(1);
                r_ch_off <= r_ch_off + 32'(r_stride);
            end else begin
                r_ch_cnt <= '0;
                r_ch_off <= '0;
                if (!w_wb_last) begin
                    r_wb_cnt <= r_wb_cnt + c_wbw'(1);
                    r_wb_off <= r_wb_off + c_wb_step;
                end else begin
                    r_wb_cnt <= '0;
                    r_wb_off <= '0;
                    if (!w_h_last) begin
                        r_h_cnt <= r_h_cnt + LOG2_H'(1);
                        r_h_off <= r_h_off + r_hstep;
                    end else begin
                        r_h_cnt <= '0;
                        r_h_off <= '0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response loop counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_rch_cnt  <= '0;
            r_rwb_cnt  <= '0;
            r_rh_cnt   <= '0;
            r_rh_pix   <= '0;
        end else if (w_start) begin
            r_beat_cnt <= '0;
            r_rch_cnt  <= '0;
            r_rwb_cnt  <= '0;
            r_rh_cnt   <= '0;
            r_rh_pix   <= '0;
        end else if (w_beat_acc) begin
            if (!w_beat_last) begin
                r_beat_cnt <= r_beat_cnt + LOG2_BURST'(1);
            end else begin
                r_beat_cnt <= '0;
                if (!w_rch_last) begin
                    r_rch_cnt <= r_rch_cnt + c_chw'(1);
                end else begin
                    r_rch_cnt <= '0;
                    if (!w_rwb_last) begin
                        r_rwb_cnt <= r_rwb_cnt + c_wbw'(1);
                    end else begin
                        r_rwb_cnt <= '0;
                        if (!w_rh_last) begin
                            r_rh_cnt <= r_rh_cnt + LOG2_H'(1);
                            r_rh_pix <= r_rh_pix + 32'(r_w);
                        end else begin
                            r_rh_cnt <= '0;
                            r_rh_pix <= '0;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bursts in flight.
    // A command handshake and a burst completion in the same cycle
    // cancel each other out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else if (w_cmd_hs && !w_burst_end) begin
            r_outstanding <= r_outstanding + c_ow'(1);
        end else if (!w_cmd_hs && w_burst_end) begin
            r_outstanding <= r_outstanding - c_ow'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_softmax_rdma.sv
`default_nettype none
// ============================================================================
// Module      : tb_softmax_rdma
// Description : Self-checking bench for softmax_rdma.
//               - A job model pushes the expected commands and masked beats
//                 into scoreboard queues.
//               - A small MCIF model answers the DUT's commands in order.
//               - A monitor pops the queues and compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_rdma;

    localparam int c_dw = 128;
    localparam int c_pw = 68;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [11:0]        w;
    logic [11:0]        h;
    logic [15:0]        pixel_in;
    logic [8:0]         ch_div_Tout;
    logic [31:0]        feature_base_addr;
    logic [25:0]        feature_surface_stride;
    logic               rdma_done;
    logic               rd_req_vld;
    logic               rd_req_rdy;
    logic [c_pw-1:0]    rd_req_pd;
    logic               rd_rsp_vld;
    logic [c_dw-1:0]    rd_rsp_pd;
    logic               rd_rsp_rdy;
    logic               dat_out_vld;
    logic [c_dw-1:0]    dat_out_pd;
    logic               dat_out_rdy;

    always #5 clk = ~clk;

    softmax_rdma u_dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start                  (start),
        .w                      (w),
        .h                      (h),
        .pixel_in               (pixel_in),
        .ch_div_Tout            (ch_div_Tout),
        .feature_base_addr      (feature_base_addr),
        .feature_surface_stride (feature_surface_stride),
        .rdma_done              (rdma_done),
        .rd_req_vld             (rd_req_vld),
        .rd_req_rdy             (rd_req_rdy),
        .rd_req_pd              (rd_req_pd),
        .rd_rsp_vld             (rd_rsp_vld),
        .rd_rsp_pd              (rd_rsp_pd),
        .rd_rsp_rdy             (rd_rsp_rdy),
        .dat_out_vld            (dat_out_vld),
        .dat_out_pd             (dat_out_pd),
        .dat_out_rdy            (dat_out_rdy)
    );

    int checks = 0;
    int errors = 0;

    logic [c_pw-1:0] exp_cmd_q[$];
    logic [c_dw-1:0] exp_dat_q[$];
    logic [c_pw-1:0] mcif_q[$];

    int   cyc = 0;
    int   cmd_count = 0;
    int   beat_count = 0;
    int   done_count = 0;
    int   t_last_beat = 0;
    int   t_done = 0;
    int   t_cmd_last = 0;
    int   t_burst_end_last = 0;
    int   mcif_beat = 0;
    logic hs_cmd = 1'b0;
    logic hs_rsp = 1'b0;
    logic [c_pw-1:0] hs_cmd_pd = '0;
    bit   withhold = 1'b0;
    bit   req_rand = 1'b0;
    bit   out_rand = 1'b0;

    function automatic logic [c_dw-1:0] pat(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_C3C3, a + 32'h1357_9BDF};
    endfunction

    task automatic check(input string tag, input logic [c_dw-1:0] obs, input logic [c_dw-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: sample on the falling edge, compare against the scoreboard
    always @(negedge clk) begin
        cyc++;
        hs_cmd = 1'b0;
        hs_rsp = 1'b0;
        if (rst_n) begin
            if (rd_req_vld && rd_req_rdy) begin
                hs_cmd     = 1'b1;
                hs_cmd_pd  = rd_req_pd;
                cmd_count++;
                t_cmd_last = cyc;
                check("cmd_expected", c_dw'(exp_cmd_q.size() != 0), 1);
                if (exp_cmd_q.size() != 0) begin
                    check("cmd_pd", rd_req_pd, exp_cmd_q.pop_front());
                end
            end
            if (rd_rsp_vld && rd_rsp_rdy) begin
                hs_rsp = 1'b1;
                if (mcif_q.size() != 0 && mcif_beat == int'(mcif_q[0][35:32])) begin
                    t_burst_end_last = cyc;
                end
            end
            if (dat_out_vld && dat_out_rdy) begin
                beat_count++;
                check("beat_expected", c_dw'(exp_dat_q.size() != 0), 1);
                if (exp_dat_q.size() != 0) begin
                    check("beat_pd", dat_out_pd, exp_dat_q.pop_front());
                    if (exp_dat_q.size() == 0) begin
                        t_last_beat = cyc;
                    end
                end
            end
            if (rdma_done) begin
                done_count++;
                t_done = cyc;
            end
        end
    end

    // MCIF model and handshake-side drivers, updated just after the rising edge
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mcif_q.delete();
            mcif_beat   = 0;
            rd_rsp_vld  = 1'b0;
            rd_rsp_pd   = '0;
            rd_req_rdy  = 1'b1;
            dat_out_rdy = 1'b1;
        end else begin
            if (hs_rsp && mcif_q.size() != 0) begin
                if (mcif_beat == int'(mcif_q[0][35:32])) begin
                    void'(mcif_q.pop_front());
                    mcif_beat = 0;
                end else begin
                    mcif_beat++;
                end
            end
            if (hs_cmd) begin
                mcif_q.push_back(hs_cmd_pd);
            end
            rd_req_rdy  = req_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            dat_out_rdy = out_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!withhold && mcif_q.size() != 0) begin
                rd_rsp_vld = 1'b1;
                rd_rsp_pd  = pat(mcif_q[0][67:36] + mcif_q[0][31:0] + 32'(mcif_beat) * 32'd16);
            end else begin
                rd_rsp_vld = 1'b0;
                rd_rsp_pd  = '0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected command stream and masked beat stream for one job
    task automatic push_job(input int jw, input int jh, input int jpix, input int jchd,
                            input logic [31:0] jbase, input logic [31:0] jstride);
        int nwb;
        nwb = (jw + 15) / 16;
        for (int hh = 0; hh < jh; hh++) begin
            for (int wb = 0; wb < nwb; wb++) begin
                for (int c = 0; c < jchd; c++) begin
                    int          beats;
                    logic [31:0] off;
                    beats = (jw - wb * 16 < 16) ? (jw - wb * 16) : 16;
                    off   = 32'(hh * jw * 16) + 32'(wb * 256) + 32'(c) * jstride;
                    exp_cmd_q.push_back({jbase, 4'(beats - 1), off});
                    for (int b = 0; b < beats; b++) begin
                        int pix;
                        pix = hh * jw + wb * 16 + b;
                        exp_dat_q.push_back((pix >= jpix) ? '0 : pat(jbase + off + 32'(b * 16)));
                    end
                end
            end
        end
    endtask

    task automatic start_job(input int jw, input int jh, input int jpix, input int jchd,
                             input logic [31:0] jbase, input logic [31:0] jstride);
        w                      = 12'(jw);
        h                      = 12'(jh);
        pixel_in               = 16'(jpix);
        ch_div_Tout            = 9'(jchd);
        feature_base_addr      = jbase;
        feature_surface_stride = 26'(jstride);
        start                  = 1'b1;
        tick(1);
        start                  = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (done_count < target && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, c_dw'(done_count >= target), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_vld"}, rd_req_vld, 0);
        check({tag, "_done"}, rdma_done, 0);
        check({tag, "_out_vld"}, dat_out_vld, 0);
        check({tag, "_rsp_rdy"}, rd_rsp_rdy, 0);
    endtask

    initial begin
        int d0;
        int b0;
        int c0;
        int n;

        rst_n                  = 1'b0;
        start                  = 1'b0;
        w                      = '0;
        h                      = '0;
        pixel_in               = '0;
        ch_div_Tout            = '0;
        feature_base_addr      = '0;
        feature_surface_stride = '0;
        tick(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(2);
        check_idle_outputs("post_reset");

        // Single full burst, unmasked
        d0 = done_count; b0 = beat_count; c0 = cmd_count;
        push_job(16, 1, 16, 1, 32'h0, 32'h0);
        start_job(16, 1, 16, 1, 32'h0, 32'h0);
        wait_done(d0 + 1, 300, "t1_done_seen");
        tick(4);
        check("t1_done_once", done_count, d0 + 1);
        check("t1_done_latency", t_done - t_last_beat, 1);
        check("t1_beats", beat_count - b0, 16);
        check("t1_cmds", cmd_count - c0, 1);

        // Partial last burst, two channel groups, two rows
        d0 = done_count; b0 = beat_count; c0 = cmd_count;
        push_job(20, 2, 100, 2, 32'h8000_0000, 32'h1000);
        start_job(20, 2, 100, 2, 32'h8000_0000, 32'h1000);
        wait_done(d0 + 1, 1000, "t2_done_seen");
        tick(4);
        check("t2_done_once", done_count, d0 + 1);
        check("t2_beats", beat_count - b0, 80);
        check("t2_cmds", cmd_count - c0, 8);

        // Pixel masking on the second row
        d0 = done_count; b0 = beat_count;
        push_job(8, 2, 12, 1, 32'h100, 32'h40);
        start_job(8, 2, 12, 1, 32'h100, 32'h40);
        wait_done(d0 + 1, 300, "t3_done_seen");
        tick(4);
        check("t3_beats", beat_count - b0, 16);
        check("t3_queues_empty", exp_cmd_q.size() + exp_dat_q.size(), 0);

        // Outstanding limit with responses withheld
        d0 = done_count; b0 = beat_count; c0 = cmd_count;
        withhold = 1'b1;
        push_job(48, 2, 65535, 1, 32'h2000, 32'h0);
        start_job(48, 2, 65535, 1, 32'h2000, 32'h0);
        tick(30);
        check("t4_cmds_capped", cmd_count - c0, 4);
        check("t4_req_vld_blocked", rd_req_vld, 0);
        withhold = 1'b0;
        n = 0;
        while (cmd_count - c0 < 5 && n < 200) begin
            tick(1);
            n++;
        end
        check("t4_fifth_cmd_seen", c_dw'(cmd_count - c0 >= 5), 1);
        check("t4_fifth_cmd_gap", t_cmd_last - t_burst_end_last, 1);
        wait_done(d0 + 1, 1000, "t4_done_seen");
        tick(4);
        check("t4_cmds", cmd_count - c0, 6);
        check("t4_beats", beat_count - b0, 96);

        // Random back-pressure plus an ignored mid-run start
        d0 = done_count; b0 = beat_count; c0 = cmd_count;
        req_rand = 1'b1;
        out_rand = 1'b1;
        push_job(40, 3, 70, 3, 32'h0001_0000, 32'h800);
        start_job(40, 3, 70, 3, 32'h0001_0000, 32'h800);
        tick(40);
        start_job(4, 1, 4, 1, 32'h0, 32'h0);
        wait_done(d0 + 1, 5000, "t5_done_seen");
        tick(10);
        req_rand = 1'b0;
        out_rand = 1'b0;
        check("t5_done_once", done_count, d0 + 1);
        check("t5_beats", beat_count - b0, 360);
        check("t5_cmds", cmd_count - c0, 27);
        check("t5_queues_empty", exp_cmd_q.size() + exp_dat_q.size(), 0);

        // Asynchronous reset mid-burst, then a clean restart
        d0 = done_count; b0 = beat_count;
        push_job(48, 2, 65535, 1, 32'h4000, 32'h0);
        start_job(48, 2, 65535, 1, 32'h4000, 32'h0);
        n = 0;
        while (beat_count - b0 < 5 && n < 200) begin
            tick(1);
            n++;
        end
        check("t6_beats_before_reset", c_dw'(beat_count - b0 >= 5), 1);
        rst_n = 1'b0;
        exp_cmd_q.delete();
        exp_dat_q.delete();
        tick(3);
        check_idle_outputs("t6_in_reset");
        rst_n = 1'b1;
        tick(5);
        check("t6_no_done_after_abort", done_count, d0);
        check_idle_outputs("t6_idle");
        c0 = cmd_count;
        push_job(4, 1, 4, 1, 32'h0, 32'h0);
        start_job(4, 1, 4, 1, 32'h0, 32'h0);
        wait_done(d0 + 1, 300, "t6_done_seen");
        tick(4);
        check("t6_done_once", done_count, d0 + 1);
        check("t6_cmds", cmd_count - c0, 1);
        check("t6_queues_empty", exp_cmd_q.size() + exp_dat_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
